// File: rtl/add_share_arbiter.sv
// add_share_arbiter
//
// Shares one WIDTH-bit add/subtract unit between NUM_REQ requesters. Each cycle,
// at most one valid request is granted. The grant is round-robin, starting from
// ptr_q. The granted operation is computed combinationally and captured in a
// single-entry output register, together with the requester index, so that the
// consumer can route the result back.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - synchronous, active-high
//   req_valid    - per-requester valid
//   req_a/req_b  - per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub      - per-requester op select (1: A-B, 0: A+B)
//   req_ready    - one-hot grant or all zero (combinational)
//   rsp_valid    - output register holds a result
//   rsp_id       - index of the requester that produced the result
//   rsp_sum      - result
//   rsp_carry    - carry out of MSB (for subtract, 1 means no borrow)
//   rsp_overflow - two's-complement signed overflow
//   rsp_ready    - consumer accepts the result

module add_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  input  logic                     rsp_ready
);

  // Round-robin pointer: the first index to consider for the next grant.
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Output register.
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_carry_q;
  logic             rsp_overflow_q;

  logic            slot_free;
  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic            accept;

  // Selected operation and arithmetic results.
  logic [WIDTH-1:0] op_a, op_b, b_eff;
  logic             op_sub;
  logic [WIDTH:0]   sum_full;
  logic             ovf;

  // Round-robin search from ptr_q. The index is computed modulo NUM_REQ in
  // ID_W+1 bits, so that NUM_REQ need not be a power of two.
  always_comb begin
    logic [ID_W:0] idx_wide;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx_wide  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_wide = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (idx_wide >= (ID_W + 1)'(NUM_REQ)) begin
        idx_wide = idx_wide - (ID_W + 1)'(NUM_REQ);
      end
      idx = idx_wide[ID_W-1:0];
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // A result can be loaded if the register is empty or is being drained this cycle.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = grant_any && slot_free && !reset;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        op_a   = req_a[i*WIDTH +: WIDTH];
        op_b   = req_b[i*WIDTH +: WIDTH];
        op_sub = req_sub[i];
      end
    end
  end

  // Subtract is A + ~B + 1, so the carry out means "no borrow".
  assign b_eff    = op_sub ? ~op_b : op_b;
  assign sum_full = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
  assign ovf      = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_sum_q      <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        // Also covers drain-and-accept in the same cycle: no bubble.
        rsp_valid_q    <= 1'b1;
        rsp_id_q       <= grant_idx;
        rsp_sum_q      <= sum_full[WIDTH-1:0];
        rsp_carry_q    <= sum_full[WIDTH];
        rsp_overflow_q <= ovf;
      end else if (rsp_ready) begin
        // Data fields keep their last value; only valid drops.
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Testbench for add_share_arbiter. A round-robin/arithmetic model predicts req_ready
// and pushes expected results into a scoreboard queue. The queue head is compared
// whenever the DUT shows rsp_valid. Directed scenarios add literal expectations.

module tb_add_share_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          carry;
    logic          ovf;
  } rsp_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_sub;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_carry;
  logic            rsp_overflow;
  logic            rsp_ready;

  rsp_t sb_q[$];
  int   grant_log[$];
  int   mptr;
  int   last_g;
  int   n_checks;
  int   n_errors;

  always #5 clock = ~clock;

  add_share_arbiter #(
    .NUM_REQ(NR),
    .WIDTH  (W),
    .ID_W   (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sub     (req_sub),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_carry   (rsp_carry),
    .rsp_overflow(rsp_overflow),
    .rsp_ready   (rsp_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t model_op(input int g);
    logic [W-1:0] a, b, beff;
    logic         s;
    logic [W:0]   full;
    rsp_t         r;
    a       = req_a[g*W +: W];
    b       = req_b[g*W +: W];
    s       = req_sub[g];
    beff    = s ? ~b : b;
    full    = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, s};
    r.id    = IW'(g);
    r.sum   = full[W-1:0];
    r.carry = full[W];
    r.ovf   = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  // One clock cycle: check at negedge, update the model, return 1ns after posedge.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    bit            free;
    int            g;
    @(negedge clock);
    last_g = -1;
    for (int i = 0; i < int'(NR); i++) begin
      if (req_ready[i] === 1'b1) last_g = i;
    end
    if (reset) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
      sb_q.delete();
      mptr = 0;
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0 && rsp_valid === 1'b1) begin
        check("sb_id", 64'(rsp_id), 64'(sb_q[0].id));
        check("sb_sum", 64'(rsp_sum), 64'(sb_q[0].sum));
        check("sb_carry", 64'(rsp_carry), 64'(sb_q[0].carry));
        check("sb_ovf", 64'(rsp_overflow), 64'(sb_q[0].ovf));
      end
      free    = (sb_q.size() == 0) || (rsp_ready == 1'b1);
      exp_rdy = '0;
      g       = -1;
      if (free) begin
        for (int k = 0; k < int'(NR); k++) begin
          int idx;
          idx = (mptr + k) % int'(NR);
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (rsp_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      if (g >= 0) begin
        sb_q.push_back(model_op(g));
        mptr = (g + 1) % int'(NR);
      end
      if (last_g >= 0) grant_log.push_back(last_g);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
    req_valid[i]    = 1'b1;
  endtask

  // Present one operation, wait (bounded) for its grant, then check the loaded result.
  task automatic run_op(input string tag, input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int n;
    set_req(i, a, b, s);
    n = 0;
    do begin
      step();
      n++;
    end while (last_g != i && n < 16);
    check({tag, "_grant"}, 64'(last_g), 64'(i));
    req_valid[i] = 1'b0;
    check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, "_id"}, 64'(rsp_id), 64'(i));
    check({tag, "_sum"}, 64'(rsp_sum), 64'(es));
    check({tag, "_carry"}, 64'(rsp_carry), 64'(ec));
    check({tag, "_ovf"}, 64'(rsp_overflow), 64'(eo));
  endtask

  initial begin
    int exp_order[6];
    n_checks  = 0;
    n_errors  = 0;
    mptr      = 0;
    last_g    = -1;
    reset     = 1'b1;
    req_valid = '1;  // requests during reset must not be granted
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    step();
    step();
    reset     = 1'b0;
    req_valid = '0;
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_id", 64'(rsp_id), 64'(0));
    check("rst_sum", 64'(rsp_sum), 64'(0));
    check("rst_carry", 64'(rsp_carry), 64'(0));
    check("rst_ovf", 64'(rsp_overflow), 64'(0));

    // Single request from requester 2.
    run_op("single", 2, 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0);

    // Round-robin with all requesters valid; reset first so ptr starts at 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    grant_log.delete();
    for (int i = 0; i < int'(NR); i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    repeat (6) step();
    exp_order = '{0, 1, 2, 3, 0, 1};
    check("rr_count", 64'(grant_log.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
      else check("rr_order", 64'(-1), 64'(exp_order[i]));
    end
    req_valid = '0;
    step();
    step();

    // Back-pressure: result held, no grants while rsp_ready is low.
    rsp_ready = 1'b0;
    run_op("bp_load", 0, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);
    set_req(1, 32'd100, 32'd1, 1'b1);
    repeat (3) begin
      step();
      check("bp_nogrant", 64'(last_g), 64'(-1));
      check("bp_hold_sum", 64'(rsp_sum), 64'(30));
      check("bp_hold_id", 64'(rsp_id), 64'(0));
    end
    rsp_ready = 1'b1;
    step();
    check("bp_grant", 64'(last_g), 64'(1));
    req_valid[1] = 1'b0;
    check("bp_next_sum", 64'(rsp_sum), 64'(99));
    check("bp_next_id", 64'(rsp_id), 64'(1));
    step();

    // Flag corner cases.
    run_op("f_ovf", 3, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("f_carry", 0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("f_subovf", 1, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("f_borrow", 2, 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    step();

    // Reset mid-operation: rsp_valid=1 and ptr=2 (after a grant to 1).
    rsp_ready = 1'b0;
    run_op("rm_load", 1, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0);
    set_req(1, 32'h10, 32'h20, 1'b0);
    set_req(3, 32'h40, 32'h8, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rm_valid", 64'(rsp_valid), 64'(0));
    check("rm_id", 64'(rsp_id), 64'(0));
    check("rm_sum", 64'(rsp_sum), 64'(0));
    check("rm_carry", 64'(rsp_carry), 64'(0));
    check("rm_ovf", 64'(rsp_overflow), 64'(0));
    rsp_ready = 1'b1;
    step();
    check("rm_first_grant", 64'(last_g), 64'(1));
    req_valid[1] = 1'b0;

    // Drain and accept in the same cycle: requester 3 still valid.
    check("da_pre_valid", 64'(rsp_valid), 64'(1));
    step();
    check("da_grant", 64'(last_g), 64'(3));
    check("da_valid", 64'(rsp_valid), 64'(1));
    check("da_id", 64'(rsp_id), 64'(3));
    check("da_sum", 64'(rsp_sum), 64'(32'h38));
    req_valid = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter that shares one WIDTH-bit add/subtract unit between NUM_REQ requesters, such as the PC incrementer, the branch-target adder and the ALU address path. Each requester uses a valid/ready handshake. The arbiter grants one request per cycle and computes sum, carry and signed overflow. It holds the result in a single-entry output register until the consumer accepts it. Results carry the requester index so the consumer can route them back.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- ID_W, $clog2(NUM_REQ), width of rsp_id.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- req_valid, input, NUM_REQ, bit i is high when requester i presents an operation.
- req_a, input, NUM_REQ*WIDTH, operand A of requester i at [i*WIDTH +: WIDTH].
- req_b, input, NUM_REQ*WIDTH, operand B of requester i at [i*WIDTH +: WIDTH].
- req_sub, input, NUM_REQ, bit i selects A−B (1) or A+B (0) for requester i.
- req_ready, output, NUM_REQ, one-hot grant or all zero; combinational.
- rsp_valid, output, 1, output register holds a result.
- rsp_id, output, ID_W, index of the requester that produced the result.
- rsp_sum, output, WIDTH, result.
- rsp_carry, output, 1, carry out of the MSB (for subtract, 1 means no borrow).
- rsp_overflow, output, 1, two's-complement signed overflow.
- rsp_ready, input, 1, consumer accepts the result.

## Operation

- Define `slot_free = !rsp_valid || rsp_ready`.
- **Grant:** when slot_free, req_ready asserts for exactly one i with req_valid[i]=1. The choice is round-robin, searching i = ptr, ptr+1, …, modulo NUM_REQ. When slot_free=0, req_ready is all zero.
- **Transfer:** a request is accepted when req_valid[i] && req_ready[i]. Requesters hold valid, a, b and sub stable until accepted; the arbiter never drops a held request.
- **Pointer update:** on acceptance from requester g, ptr ← (g+1) mod NUM_REQ. With no acceptance, ptr is unchanged.
- **Starvation bound:** a continuously valid requester is granted within NUM_REQ accepting cycles.
- **Arithmetic:** b_eff = sub ? ~b : b and cin = sub. The (WIDTH+1)-bit result of a + b_eff + cin gives rsp_sum = [WIDTH−1:0] and rsp_carry = [WIDTH].
- **Overflow:** rsp_overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- **Output register:**
  - On acceptance, load sum, carry, overflow and id, and set rsp_valid=1.
  - If rsp_valid && rsp_ready with no acceptance that cycle, clear rsp_valid.
  - Drain and accept in the same cycle load the new result, keeping rsp_valid=1 with no bubble.
- The rsp_* data outputs are stable while rsp_valid=1 and rsp_ready=0.
- **Reset:** rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_overflow=0, ptr=0. Any in-flight result is discarded. req_ready during reset is all zero.
- Operations complete in one cycle; there is no other state.

## Timing

- Latency: request accepted in cycle N, rsp_valid=1 with its result in cycle N+1.
- Throughput: one operation per cycle while rsp_ready=1.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready and ptr. Requesters must not make req_valid depend on req_ready.
- Back-pressure: with rsp_valid=1 and rsp_ready=0, no grant is issued. Pending requests wait, and ptr is frozen.
- After reset deasserts, the first grant is possible in that same cycle. Requester 0 has priority first.
- Wrap-around: after a grant to NUM_REQ−1, ptr=0.
- A sole active requester is granted every accepting cycle.

## Test plan

- Single request: req 2 presents a=0x0000_0005, b=0x0000_0003, add. Required: req_ready=0b0100 in cycle N; cycle N+1 gives rsp_valid=1, id=2, sum=0x8, carry=0, overflow=0.
- Round-robin: all four requesters are valid continuously and rsp_ready=1. Required: grant order 0,1,2,3,0,1; one result per cycle with ids in the same order.
- Back-pressure: hold rsp_ready=0 for 3 cycles with req 1 valid. Required: req_ready=0; rsp_* held unchanged; req 1 granted on the cycle rsp_ready rises, and the next result appears the following cycle.
- Flags:
  - 0x7FFF_FFFF+1 gives sum 0x8000_0000, overflow=1, carry=0.
  - 0xFFFF_FFFF+1 gives sum 0, carry=1, overflow=0.
  - sub 0x8000_0000−1 gives sum 0x7FFF_FFFF, overflow=1, carry=1.
  - sub 3−5 gives sum 0xFFFF_FFFE, carry=0, overflow=0.
- Reset mid-operation: assert reset while rsp_valid=1 and ptr=2. Required: the next cycle has rsp_valid=0 and all rsp_* = 0; the first grant after reset goes to the lowest-index valid requester from 0.
- Simultaneous drain and accept: rsp_valid=1, rsp_ready=1, req 3 valid. Required: req 3 is accepted that cycle, and rsp_valid stays 1 with id=3 next cycle.
